// File: rtl/data_ram_ws.sv
// data_ram_ws: 32-bit RAM built from four byte banks, answered through an IDLE/WAIT/ACK wait-state handshake.
// Optional build macro DATA_RAM_ALIGN_CHECK_EN rejects byte-enable patterns that are not naturally aligned.
module data_ram_ws #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready,
  output logic        err
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  logic [7:0] bank0 [DEPTH];
  logic [7:0] bank1 [DEPTH];
  logic [7:0] bank2 [DEPTH];
  logic [7:0] bank3 [DEPTH];

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] idx_r;
  logic [3:0]        sel_r;
  logic [31:0]       wdata_r;

  logic [ADDR_W-1:0] rd_idx_s;
  logic [3:0]        rd_sel_s;
  logic              rd_we_s;
  logic              legal_s;
  logic [31:0]       ack_data_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^{addr[31:ADDR_W+2], addr[1:0]};

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

`ifdef DATA_RAM_ALIGN_CHECK_EN
  function automatic logic sel_is_aligned(input logic [3:0] s);
    logic ok;
    case (s)
      4'b1111, 4'b1100, 4'b0011,
      4'b1000, 4'b0100, 4'b0010, 4'b0001: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  // Response for the access entering ACK: live inputs when coming straight from IDLE, latched ones otherwise.
  always_comb begin
    rd_idx_s = idx_r;
    rd_sel_s = sel_r;
    rd_we_s  = we_r;
    if (state_r == IDLE) begin
      rd_idx_s = addr[ADDR_W+1:2];
      rd_sel_s = sel;
      rd_we_s  = we;
    end else begin
      rd_idx_s = idx_r;
      rd_sel_s = sel_r;
      rd_we_s  = we_r;
    end
`ifdef DATA_RAM_ALIGN_CHECK_EN
    legal_s = sel_is_aligned(rd_sel_s);
`else
    legal_s = 1'b1;
`endif
    if (!rd_we_s && legal_s) begin
      ack_data_s = {bank3[rd_idx_s], bank2[rd_idx_s], bank1[rd_idx_s], bank0[rd_idx_s]}
                   & lane_mask(rd_sel_s);
    end else begin
      ack_data_s = 32'd0;
    end
  end

  // Handshake FSM; ready/err/data_o are registered and only non-zero during the ACK cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      idx_r   <= {ADDR_W{1'b0}};
      sel_r   <= 4'd0;
      wdata_r <= 32'd0;
      ready   <= 1'b0;
      err     <= 1'b0;
      data_o  <= 32'd0;
    end else begin
      ready  <= 1'b0;
      err    <= 1'b0;
      data_o <= 32'd0;
      case (state_r)
        IDLE: begin
          if (ce) begin
            we_r    <= we;
            idx_r   <= addr[ADDR_W+1:2];
            sel_r   <= sel;
            wdata_r <= data_i;
            if (WAIT_CYCLES > 0) begin
              state_r <= WAIT;
              cnt_r   <= WAIT_LOAD;
            end else begin
              state_r <= ACK;
              ready   <= 1'b1;
              err     <= !legal_s;
              data_o  <= ack_data_s;
            end
          end
        end
        WAIT: begin
          // Requester dropping ce mid-wait withdraws the request.
          if (!ce) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end else if (cnt_r == 4'd0) begin
            state_r <= ACK;
            ready   <= 1'b1;
            err     <= !legal_s;
            data_o  <= ack_data_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ACK: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Store commit on the edge ending ACK; the arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state_r == ACK && we_r && !err) begin
      if (sel_r[0]) bank0[idx_r] <= wdata_r[7:0];
      if (sel_r[1]) bank1[idx_r] <= wdata_r[15:8];
      if (sel_r[2]) bank2[idx_r] <= wdata_r[23:16];
      if (sel_r[3]) bank3[idx_r] <= wdata_r[31:24];
    end
  end

endmodule

// File: tb/tb_data_ram_ws.sv
// Scoreboard bench for data_ram_ws: one WAIT_CYCLES=2 instance and one WAIT_CYCLES=0 instance,
// each checked against a word-array reference model with randomized requests.
`timescale 1ns/1ps
module tb_data_ram_ws;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int WIN   = 16;
  localparam int W_A   = 2;
  localparam int W_B   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          at_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce   [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [3:0]  sel  [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        rdy  [2];
  logic        errs [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [2][DEPTH];
  int          ecnt   = 0;
  int          checks = 0;
  int          errors = 0;

  data_ram_ws #(.WAIT_CYCLES(W_A), .ADDR_W(AW)) dut_a (
    .clk(clk), .rst(rst), .ce(ce[0]), .we(we[0]), .addr(addr[0]), .sel(sel[0]),
    .data_i(din[0]), .data_o(dout[0]), .ready(rdy[0]), .err(errs[0]));

  data_ram_ws #(.WAIT_CYCLES(W_B), .ADDR_W(AW)) dut_b (
    .clk(clk), .rst(rst), .ce(ce[1]), .we(we[1]), .addr(addr[1]), .sel(sel[1]),
    .data_i(din[1]), .data_o(dout[1]), .ready(rdy[1]), .err(errs[1]));

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic int wc(input int u);
    return (u == 0) ? W_A : W_B;
  endfunction

  function automatic logic [31:0] dut_word(input int u, input int i);
    if (u == 0) return {dut_a.bank3[i], dut_a.bank2[i], dut_a.bank1[i], dut_a.bank0[i]};
    else        return {dut_b.bank3[i], dut_b.bank2[i], dut_b.bank1[i], dut_b.bank0[i]};
  endfunction

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (unit %0d, edge %0d): got %08h, expected %08h", name, u, ecnt, act, exp);
    end
  endtask

  // Reference model: a word array; a request's effect is applied when it is accepted.
  task automatic accept(input int u, input int acc_edge);
    exp_t        e;
    int          idx;
    logic [31:0] w;
    idx       = int'((addr[u] >> 2) % 32'(DEPTH));
    e.err     = 1'b0;
`ifdef DATA_RAM_ALIGN_CHECK_EN
    e.err     = !(sel[u] inside {4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001});
`endif
    e.data    = 32'd0;
    e.at_edge = acc_edge + wc(u);
    w         = mdl[u][idx];
    if (!e.err) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[u][b]) begin
          if (we[u]) w[8*b +: 8] = din[u][8*b +: 8];
          else       e.data[8*b +: 8] = w[8*b +: 8];
        end
      end
    end
    mdl[u][idx] = w;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic monitor(input int u);
    exp_t e;
    int   depth;
    depth = (u == 0) ? q0.size() : q1.size();
    if (rdy[u]) begin
      if (depth == 0) begin
        chk("unexpected_ready", u, {31'd0, rdy[u]}, 32'd0);
      end else begin
        if (u == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk("data_o", u, dout[u], e.data);
        chk("err", u, {31'd0, errs[u]}, {31'd0, e.err});
        chk("ready_latency", u, 32'(ecnt), 32'(e.at_edge));
      end
    end else begin
      chk("idle_data_o", u, dout[u], 32'd0);
      chk("idle_err", u, {31'd0, errs[u]}, 32'd0);
    end
  endtask

  always @(negedge clk) monitor(0);
  always @(negedge clk) monitor(1);

  task automatic scramble(input int u);
    we[u]   = 1'($urandom);
    addr[u] = $urandom;
    sel[u]  = 4'($urandom);
    din[u]  = $urandom;
  endtask

  // Waits for ready, perturbing the inputs while waiting (the DUT must use its latched copy).
  task automatic wait_ack(input int u, input int skip);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rdy[u]) seen = 1'b1;
      else if (i >= skip) scramble(u);
    end
    if (!seen) chk("ready_timeout", u, {31'd0, rdy[u]}, 32'd1);
  endtask

  // Called and returns at a negedge with the DUT idle. mode 0 single, 1 ce held across ACK, 2 abort in WAIT.
  task automatic request(input int u, input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int mode);
    ce[u] = 1'b1; we[u] = w; addr[u] = a; sel[u] = s; din[u] = d;
    if (mode == 2 && wc(u) > 0) begin
      @(negedge clk);
      ce[u] = 1'b0;
      scramble(u);
      repeat (wc(u) + 3) @(negedge clk);
    end else begin
      accept(u, ecnt + 1);
      wait_ack(u, 0);
      if (mode == 1) begin
        we[u] = w; addr[u] = a; sel[u] = s; din[u] = d;
        accept(u, ecnt + 2);
        wait_ack(u, 1);
      end
      ce[u] = 1'b0;
      scramble(u);
      @(negedge clk);
    end
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < WIN; i++) begin
      chk(name, 0, dut_word(0, i), mdl[0][i]);
      chk(name, 1, dut_word(1, i), mdl[1][i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      ce[u] = 1'b0; we[u] = 1'b0; addr[u] = 32'd0; sel[u] = 4'd0; din[u] = 32'd0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int u = 0; u < 2; u++)
      for (int i = 0; i < WIN; i++)
        request(u, 1'b1, 32'(i) << 2, 4'b1111, (i == 1) ? 32'h1122_3344 : $urandom, 0);

    request(0, 1'b1, 32'h0, 4'b1111, 32'h0000_1234, 0);
    request(1, 1'b1, 32'h0, 4'b1111, 32'h0000_1234, 0);
    chk("word0_store", 0, dut_word(0, 0), 32'h0000_1234);

    request(0, 1'b1, 32'h4, 4'b0011, 32'h89AB_89AB, 0);
    chk("word1_partial_store", 0, dut_word(0, 1), 32'h1122_89AB);
    request(0, 1'b0, 32'h4, 4'b1111, 32'd0, 0);
    request(0, 1'b0, 32'h4, 4'b1111, 32'd0, 1);
    request(1, 1'b0, 32'h0, 4'b1111, 32'd0, 0);
    request(1, 1'b0, 32'h0, 4'b1111, 32'd0, 1);

    request(0, 1'b1, 32'h0, 4'b0110, 32'hA5A5_A5A5, 0);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    chk("sel0110_store_blocked", 0, dut_word(0, 0), 32'h0000_1234);
`else
    chk("sel0110_store_middle", 0, dut_word(0, 0), 32'h00A5_A534);
`endif
    request(0, 1'b0, 32'h0, 4'b0110, 32'd0, 0);

    request(0, 1'b1, 32'hC, 4'b1111, 32'hCAFE_F00D, 2);
    request(0, 1'b0, 32'hC, 4'b1111, 32'd0, 0);

    // Reset while the W=2 instance is in WAIT with a pending store.
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; sel[0] = 4'b1111; din[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0; ce[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("word2_reset_in_wait", 0, dut_word(0, 2), mdl[0][2]);

    // Reset during the ACK cycle of the zero-wait instance.
    ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'hC; sel[1] = 4'b1111; din[1] = 32'hDEAD_BEEF;
    @(posedge clk);
    #2 rst = 1'b0; ce[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("word3_reset_in_ack", 1, dut_word(1, 3), mdl[1][3]);

    sweep("mem_directed");

    for (int n = 0; n < 300; n++) begin
      int          u;
      int          r;
      int          mode;
      logic [31:0] a;
      u    = int'($urandom_range(1, 0));
      r    = int'($urandom_range(9, 0));
      mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(WIN - 1, 0)) << 2) | ($urandom & 32'h3);
      request(u, 1'($urandom), a, 4'($urandom), $urandom, mode);
    end

    repeat (2) @(negedge clk);
    sweep("mem_final");
    chk("queue0_drained", 0, 32'(q0.size()), 32'd0);
    chk("queue1_drained", 1, 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
